crc32_stream_engine: RTL and testbench

Streaming, parametrised CRC-32 engine. It accepts a byte-lane data stream of configurable width over a valid/ready handshake and keeps a running CRC across beats. At frame end it emits one registered CRC result and the frame byte count on a second valid/ready handshake. It is the sequential successor of the single-cycle 32-bit CRC combinational slice and sits between the packet front-end and the checksum compare/insert logic.

---
 rtl/crc32_stream_engine.sv | 72 +++++++
 tb/tb_crc32_stream_engine.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine: streaming byte-lane CRC-32 with running accumulator and registered frame result
module crc32_stream_engine #(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [31:0] POLY = 32'h04C11DB7,
  parameter logic [31:0] INIT = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter logic REFLECT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8*DATA_BYTES-1:0] s_data,
  input  logic [DATA_BYTES-1:0]   s_keep,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [31:0]             m_crc,
  output logic [15:0]             m_len
);
  logic [31:0] crc_q, crc_next;
  logic [15:0] len_q, len_next;
  logic [16:0] len_sum;
  logic [3:0] cnt;
  logic take;
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction
  // crc_q is kept bit-reversed relative to the normal form, so REFLECT=0 works on rev32(crc_q)
  function automatic logic [31:0] upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = REFLECT ? c ^ {24'd0, b} : rev32(c) ^ {b, 24'd0};
    for (int k = 0; k < 8; k++)
      r = REFLECT ? (r >> 1) ^ (r[0] ? rev32(POLY) : 32'd0)
                  : (r << 1) ^ (r[31] ? POLY : 32'd0);
    return REFLECT ? r : rev32(r);
  endfunction
  assign s_ready = !m_valid || m_ready;
  assign take = s_valid && s_ready;
  always_comb begin
    crc_next = crc_q;
    cnt = '0;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      crc_next = s_keep[i] ? upd(crc_next, s_data[8*i +: 8]) : crc_next;
      cnt = cnt + 4'(s_keep[i]);
    end
    len_sum = {1'b0, len_q} + 17'(cnt);
    len_next = len_sum[16] ? 16'hFFFF : len_sum[15:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= INIT;
      len_q <= '0;
      m_valid <= 1'b0;
      m_crc <= '0;
      m_len <= '0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      if (take) begin
        crc_q <= s_last ? INIT : crc_next;
        len_q <= s_last ? 16'd0 : len_next;
        if (s_last) begin
          m_valid <= 1'b1;
          m_crc <= (REFLECT ? crc_next : rev32(crc_next)) ^ XOR_OUT;
          m_len <= len_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_crc32_stream_engine.sv
// tb_crc32_stream_engine: randomized self-checking bench against a bit-serial CRC reference model
module tb_crc32_stream_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic s_valid, s_ready, s_last, m_valid, m_ready;
  logic [31:0] s_data, m_crc;
  logic [3:0] s_keep;
  logic [15:0] m_len;
  logic b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready;
  logic [7:0] b_s_data;
  logic [0:0] b_s_keep;
  logic [31:0] b_m_crc;
  logic [15:0] b_m_len;
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] fq[$];

  crc32_stream_engine u_iso (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_keep(s_keep), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_crc(m_crc), .m_len(m_len)
  );

  crc32_stream_engine #(.DATA_BYTES(1), .REFLECT(1'b0)) u_bz (
    .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .s_keep(b_s_keep), .s_last(b_s_last), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_crc(b_m_crc), .m_len(b_m_len)
  );

  // Message treated as a bit sequence divided by the generator (init FFFFFFFF, xorout FFFFFFFF)
  function automatic logic [31:0] ref_crc(input logic [7:0] q[$], input logic refl);
    logic [31:0] c, r;
    logic bin;
    c = 32'hFFFFFFFF;
    foreach (q[n])
      for (int k = 0; k < 8; k++) begin
        bin = refl ? q[n][k] : q[n][7-k];
        c = {c[30:0], 1'b0} ^ ((c[31] ^ bin) ? 32'h04C11DB7 : 32'd0);
      end
    for (int i = 0; i < 32; i++) r[i] = refl ? c[31-i] : c[i];
    return r ^ 32'hFFFFFFFF;
  endfunction

  function automatic logic [15:0] ref_len(input int n);
    return n > 65535 ? 16'hFFFF : 16'(n);
  endfunction

  task automatic push_bytes(input logic [31:0] d, input logic [3:0] k);
    for (int i = 0; i < 4; i++) if (k[i]) fq.push_back(d[8*i +: 8]);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    push_bytes(d, k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_keep = '0; b_s_last = 1'b0; b_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 4;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    if (m_crc !== 32'd0) begin n_bad++; $display("FAIL reset_m_crc: got %h want 0", m_crc); end
    if (m_len !== 16'd0) begin n_bad++; $display("FAIL reset_m_len: got %h want 0", m_len); end
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_iso_check();
    m_ready = 1'b1;
    fq.delete();
    send_beat(32'h34333231, 4'hF, 1'b0);
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL iso_early_valid: got %b want 0", m_valid); end
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'h00000039, 4'h1, 1'b1);
    n_cmp += 4;
    if (m_valid !== 1'b1) begin n_bad++; $display("FAIL iso_latency: m_valid=%b want 1", m_valid); end
    if (m_crc !== 32'hCBF43926) begin n_bad++; $display("FAIL iso_crc: got %h want CBF43926", m_crc); end
    if (m_crc !== ref_crc(fq, 1'b1)) begin n_bad++; $display("FAIL iso_model: got %h want %h", m_crc, ref_crc(fq, 1'b1)); end
    if (m_len !== 16'd9) begin n_bad++; $display("FAIL iso_len: got %0d want 9", m_len); end
    fq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_bzip2();
    string s = "123456789";
    logic [7:0] q[$];
    for (int i = 0; i < 9; i++) begin
      b_s_valid = 1'b1; b_s_data = s[i]; b_s_keep = 1'b1; b_s_last = (i == 8);
      q.push_back(s[i]);
      @(posedge clk); #1;
    end
    b_s_valid = 1'b0;
    n_cmp += 4;
    if (b_m_valid !== 1'b1) begin n_bad++; $display("FAIL bz_valid: got %b want 1", b_m_valid); end
    if (b_m_crc !== 32'hFC891918) begin n_bad++; $display("FAIL bz_crc: got %h want FC891918", b_m_crc); end
    if (b_m_crc !== ref_crc(q, 1'b0)) begin n_bad++; $display("FAIL bz_model: got %h want %h", b_m_crc, ref_crc(q, 1'b0)); end
    if (b_m_len !== 16'd9) begin n_bad++; $display("FAIL bz_len: got %0d want 9", b_m_len); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_empty();
    m_ready = 1'b1;
    fq.delete();
    send_beat(32'hAABBCC61, 4'h1, 1'b1);
    n_cmp += 2;
    if (m_crc !== 32'hE8B7BE43) begin n_bad++; $display("FAIL single_crc: got %h want E8B7BE43", m_crc); end
    if (m_len !== 16'd1) begin n_bad++; $display("FAIL single_len: got %0d want 1", m_len); end
    fq.delete();
    send_beat($urandom, 4'h0, 1'b1);
    n_cmp += 3;
    if (m_valid !== 1'b1) begin n_bad++; $display("FAIL empty_valid: got %b want 1", m_valid); end
    if (m_crc !== 32'h00000000) begin n_bad++; $display("FAIL empty_crc: got %h want 00000000", m_crc); end
    if (m_len !== 16'd0) begin n_bad++; $display("FAIL empty_len: got %0d want 0", m_len); end
    fq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] ca, cb, d;
    logic [15:0] la, lb;
    logic [3:0] k;
    m_ready = 1'b0;
    fq.delete();
    d = $urandom; k = 4'($urandom_range(1, 15));
    send_beat(d, k, 1'b1);
    ca = ref_crc(fq, 1'b1); la = ref_len(fq.size());
    fq.delete();
    n_cmp++;
    if (m_valid !== 1'b1 || m_crc !== ca || m_len !== la)
      begin n_bad++; $display("FAIL bp_first: v=%b crc=%h len=%0d want 1 %h %0d", m_valid, m_crc, m_len, ca, la); end
    d = $urandom; k = 4'($urandom_range(1, 15));
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = 1'b1;
    push_bytes(d, k);
    cb = ref_crc(fq, 1'b1); lb = ref_len(fq.size());
    fq.delete();
    repeat (5) begin
      @(posedge clk); #1;
      n_cmp++;
      if (m_valid !== 1'b1 || m_crc !== ca || m_len !== la || s_ready !== 1'b0)
        begin n_bad++; $display("FAIL bp_hold: v=%b crc=%h len=%0d rdy=%b want 1 %h %0d 0", m_valid, m_crc, m_len, s_ready, ca, la); end
    end
    m_ready = 1'b1;
    #1;
    n_cmp++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b1 || m_crc !== cb || m_len !== lb)
      begin n_bad++; $display("FAIL bp_second: v=%b crc=%h len=%0d want 1 %h %0d", m_valid, m_crc, m_len, cb, lb); end
    @(posedge clk); #1;
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: m_valid=%b want 0", m_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic [3:0] k;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = $urandom; k = 4'($urandom);
      s_valid = 1'b1; s_data = d; s_keep = k; s_last = 1'b1;
      n_cmp++;
      if (s_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, s_ready); end
      @(posedge clk); #1;
      fq.delete();
      push_bytes(d, k);
      n_cmp++;
      if (m_valid !== 1'b1 || m_crc !== ref_crc(fq, 1'b1) || m_len !== ref_len(fq.size()))
        begin n_bad++; $display("FAIL b2b[%0d]: v=%b crc=%h len=%0d want 1 %h %0d", i, m_valid, m_crc, m_len, ref_crc(fq, 1'b1), fq.size()); end
    end
    s_valid = 1'b0;
    fq.delete();
    @(posedge clk); #1;
    n_cmp++;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_end: m_valid=%b want 0", m_valid); end
  endtask

  task automatic test_random_frames();
    int nb;
    m_ready = 1'b1;
    for (int f = 0; f < 20; f++) begin
      fq.delete();
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_beat($urandom, 4'($urandom), b == nb - 1);
      end
      n_cmp++;
      if (m_valid !== 1'b1 || m_crc !== ref_crc(fq, 1'b1) || m_len !== ref_len(fq.size()))
        begin n_bad++; $display("FAIL rand_frame[%0d]: v=%b crc=%h len=%0d want 1 %h %0d", f, m_valid, m_crc, m_len, ref_crc(fq, 1'b1), fq.size()); end
    end
    fq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_saturation();
    logic [31:0] d;
    m_ready = 1'b1;
    fq.delete();
    for (int i = 0; i < 16400; i++) begin
      d = $urandom;
      s_valid = 1'b1; s_data = d; s_keep = 4'hF; s_last = (i == 16399);
      push_bytes(d, 4'hF);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n_cmp += 2;
    if (m_len !== 16'hFFFF) begin n_bad++; $display("FAIL sat_len: got %h want FFFF", m_len); end
    if (m_crc !== ref_crc(fq, 1'b1)) begin n_bad++; $display("FAIL sat_crc: got %h want %h", m_crc, ref_crc(fq, 1'b1)); end
    fq.delete();
    send_beat(32'h34333231, 4'h3, 1'b1);
    n_cmp++;
    if (m_len !== 16'd2) begin n_bad++; $display("FAIL sat_restart_len: got %0d want 2", m_len); end
    fq.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b1;
    fq.delete();
    send_beat(32'h34333231, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    fq.delete();
    send_beat(32'h34333231, 4'hF, 1'b0);
    send_beat(32'h38373635, 4'hF, 1'b0);
    send_beat(32'h00000039, 4'h1, 1'b1);
    n_cmp += 2;
    if (m_crc !== 32'hCBF43926) begin n_bad++; $display("FAIL rstmid_crc: got %h want CBF43926", m_crc); end
    if (m_len !== 16'd9) begin n_bad++; $display("FAIL rstmid_len: got %0d want 9", m_len); end
    fq.delete();
    @(posedge clk); #1;
    m_ready = 1'b0;
    send_beat($urandom, 4'hF, 1'b1);
    fq.delete();
    n_cmp++;
    if (m_valid !== 1'b1) begin n_bad++; $display("FAIL rsthold_pre: m_valid=%b want 1", m_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp += 3;
    if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rsthold_valid: got %b want 0", m_valid); end
    if (m_crc !== 32'd0) begin n_bad++; $display("FAIL rsthold_crc: got %h want 0", m_crc); end
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL rsthold_ready: got %b want 1", s_ready); end
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_iso_check();
    test_bzip2();
    test_single_empty();
    test_backpressure();
    test_back_to_back();
    test_random_frames();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
